// File: rtl/spi_host_pkg.sv
// Shared definitions for the Ascon SPI host controller: FSM encoding, frame sizes
// and the command opcodes understood by the subnode.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } state_t;

    localparam int CMD_BITS = 8;
    localparam int REG_BITS = 128;

    localparam logic [7:0] OP_REG_WRITE   = 8'h01;
    localparam logic [7:0] OP_REG_READ    = 8'h02;
    localparam logic [7:0] OP_MODE_START  = 8'h03;
    localparam logic [7:0] OP_STATE_SHIFT = 8'h04;

endpackage

// File: rtl/spi_host_tick.sv
// Phase timer: pulses phase_end on the last cycle of every CLK_DIV-cycle phase
// while run is high, and sits reloaded while run is low.
module spi_host_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase_end
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign phase_end = run && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CW'(CLK_DIV - 1);
        end else if (!run || cnt == '0) begin
            cnt <= CW'(CLK_DIV - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_host_ctrl.sv
// Host-side SPI mode-0 controller: sends a command byte plus 0..MAX_BYTES payload
// bytes MSB first and captures miso. Define SPI_HOST_MISO_SYNC_EN to synchronise miso.
module spi_host_ctrl
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          cmd,
    input  logic [4:0]          tx_len,
    input  logic [127:0]        tx_data,
    output logic                busy,
    output logic                done,
    output logic [127:0]        rx_data,
    output logic                csb,
    output logic                sck,
    output logic                mosi,
    input  logic                miso
);

    localparam int SH_BITS = CMD_BITS + REG_BITS;

    state_t               state, state_n;
    logic [SH_BITS-1:0]   sh, sh_n;
    logic [REG_BITS-1:0]  rx_n;
    logic [7:0]           nbits, nbits_n;
    logic [7:0]           bit_cnt, bit_n;
    logic [7:0]           len_c;
    logic                 high, high_n;
    logic                 phase_end;
    logic                 miso_s;
    logic                 csb_n, sck_n, mosi_n, busy_n, done_n;

`ifdef SPI_HOST_MISO_SYNC_EN
    sync_2ff u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (miso),
        .q     (miso_s)
    );
`else
    assign miso_s = miso;
`endif

    spi_host_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state != IDLE && state != DONE),
        .phase_end (phase_end)
    );

    // Next-state logic; pin outputs are derived from the next state so that the
    // registered copies line up with the state they belong to.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        rx_n    = rx_data;
        nbits_n = nbits;
        bit_n   = bit_cnt;
        high_n  = high;
        len_c   = ({3'b000, tx_len} > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : {3'b000, tx_len};

        case (state)
            IDLE: begin
                if (start) begin
                    sh_n    = {cmd, tx_data};
                    nbits_n = 8'(CMD_BITS) + {len_c[4:0], 3'b000};
                    rx_n    = '0;
                    bit_n   = '0;
                    high_n  = 1'b0;
                    state_n = SETUP;
                end
            end
            SETUP: if (phase_end) state_n = SHIFT;
            SHIFT: begin
                if (phase_end) begin
                    if (!high) begin
                        high_n = 1'b1;
                    end else begin
                        high_n = 1'b0;
                        sh_n   = {sh[SH_BITS-2:0], 1'b0};
                        bit_n  = bit_cnt + 8'd1;
                        if (bit_cnt >= 8'(CMD_BITS)) begin
                            rx_n = {rx_data[REG_BITS-2:0], miso_s};
                        end
                        if (bit_cnt == nbits - 8'd1) begin
                            state_n = HOLD;
                        end
                    end
                end
            end
            HOLD:    if (phase_end) state_n = GAP;
            GAP:     if (phase_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        csb_n  = !(state_n == SETUP || state_n == SHIFT || state_n == HOLD);
        sck_n  = (state_n == SHIFT) && high_n;
        mosi_n = (state_n == SETUP || state_n == SHIFT) ? sh_n[SH_BITS-1] : 1'b0;
        busy_n = !(state_n == IDLE || state_n == DONE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            rx_data <= '0;
            nbits   <= '0;
            bit_cnt <= '0;
            high    <= 1'b0;
            csb     <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            rx_data <= rx_n;
            nbits   <= nbits_n;
            bit_cnt <= bit_n;
            high    <= high_n;
            csb     <= csb_n;
            sck     <= sck_n;
            mosi    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule
